bnn_class_accum: RTL

BNN_CLASS_ACCUM -- requirements
Module: bnn_class_accum

---
 rtl/bnn_class_accum_if.sv | 27 ++
 rtl/bnn_class_accum.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bnn_class_accum_if.sv
// Handshake bundle between the BNN neuron layer, the class accumulator and the result consumer.
// The slave side is the accumulator; the master side drives samples and takes results.
interface bnn_class_accum_if #(
    parameter int NUM_NEURONS = 4,
    parameter int CNT_W       = 4
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_NEURONS-1:0] in_act;
    logic                   out_valid;
    logic                   out_ready;
    logic [IDX_W-1:0]       out_class;
    logic [CNT_W-1:0]       out_count;
    logic                   out_tie;

    modport master (
        output in_valid, in_act, out_ready,
        input  in_ready, out_valid, out_class, out_count, out_tie
    );

    modport slave (
        input  in_valid, in_act, out_ready,
        output in_ready, out_valid, out_class, out_count, out_tie
    );
endinterface

// File: rtl/bnn_class_accum.sv
// Accumulates per-neuron votes over WINDOW binary activation samples, then scans the
// counters one neuron per cycle to find the winning class (lowest index wins ties).
module bnn_class_accum #(
    parameter int NUM_NEURONS = 4,
    parameter int WINDOW      = 8,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    bnn_class_accum_if.slave bus
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] LAST_K      = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        ARGMAX = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg [NUM_NEURONS];
    logic [CNT_W-1:0] sample_cnt_reg, sample_cnt_next;
    logic [IDX_W-1:0] k_reg, k_next;
    logic [IDX_W-1:0] best_idx_reg, best_idx_next;
    logic [CNT_W-1:0] best_cnt_reg, best_cnt_next;
    logic             tie_reg, tie_next;
    logic             accept;
    logic             clear_counts;
    logic [CNT_W-1:0] count_at_k;

    // Ready is a pure state decode, so acceptance never depends combinationally on ready.
    assign accept     = (state_reg == ACCUM) && bus.in_valid;
    assign count_at_k = count_reg[k_reg];

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        k_next          = k_reg;
        best_idx_next   = best_idx_reg;
        best_cnt_next   = best_cnt_reg;
        tie_next        = tie_reg;
        clear_counts    = 1'b0;

        if (flush) begin
            state_next      = ACCUM;
            sample_cnt_next = '0;
            k_next          = '0;
            best_idx_next   = '0;
            best_cnt_next   = '0;
            tie_next        = 1'b0;
            clear_counts    = 1'b1;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        sample_cnt_next = sample_cnt_reg + 1'b1;
                        if (sample_cnt_reg == LAST_SAMPLE) begin
                            state_next = ARGMAX;
                            k_next     = '0;
                        end
                    end
                end
                ARGMAX: begin
                    if (k_reg == '0) begin
                        best_idx_next = '0;
                        best_cnt_next = count_at_k;
                        tie_next      = 1'b0;
                    end else if (count_at_k > best_cnt_reg) begin
                        best_idx_next = k_reg;
                        best_cnt_next = count_at_k;
                        tie_next      = 1'b0;
                    end else if (count_at_k == best_cnt_reg) begin
                        tie_next = 1'b1;
                    end
                    if (k_reg == LAST_K) begin
                        state_next = HOLD;
                    end else begin
                        k_next = k_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_next      = ACCUM;
                        sample_cnt_next = '0;
                        clear_counts    = 1'b1;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ACCUM;
            sample_cnt_reg <= '0;
            k_reg          <= '0;
            best_idx_reg   <= '0;
            best_cnt_reg   <= '0;
            tie_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            k_reg          <= k_next;
            best_idx_reg   <= best_idx_next;
            best_cnt_reg   <= best_cnt_next;
            tie_reg        <= tie_next;
        end
    end

    // WINDOW fits in CNT_W bits, so a vote counter can never wrap.
    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_vote
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_reg[gi] <= '0;
                end else if (clear_counts) begin
                    count_reg[gi] <= '0;
                end else if (accept) begin
                    count_reg[gi] <= count_reg[gi] + CNT_W'(bus.in_act[gi]);
                end
            end
        end
    endgenerate

    assign bus.in_ready  = (state_reg == ACCUM);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_class = (state_reg == HOLD) ? best_idx_reg : '0;
    assign bus.out_count = (state_reg == HOLD) ? best_cnt_reg : '0;
    assign bus.out_tie   = (state_reg == HOLD) ? tie_reg : 1'b0;

endmodule
